// File: rtl/riscv_lsu_pkg.sv
// riscv_lsu_pkg: funct3 access codes and LSU state encoding shared by the load/store path.
package riscv_lsu_pkg;
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;
    typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} lsu_state_e;
endpackage

// File: rtl/lsu_load_align.sv
// lsu_load_align: picks the addressed byte/half out of a read word and sign/zero-extends it.
module lsu_load_align
    import riscv_lsu_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  off,
    input  logic [2:0]  funct3,
    output logic [31:0] result
);
    logic [7:0]  b;
    logic [15:0] h;
    always_comb begin
        b      = rdata[{off, 3'b000} +: 8];
        h      = off[1] ? rdata[31:16] : rdata[15:0];
        result = funct3 == F3_B  ? {{24{b[7]}}, b}  :
                 funct3 == F3_H  ? {{16{h[15]}}, h} :
                 funct3 == F3_BU ? {24'b0, b}       :
                 funct3 == F3_HU ? {16'b0, h}       : rdata;
    end
endmodule

// File: rtl/mem_stage_lsu.sv
// mem_stage_lsu: M-stage load/store unit driving a valid/ready data bus and stalling the pipe.
// Define LSU_MISALIGN_TRAP_EN to suppress misaligned accesses and flag them on MisalignM.
module mem_stage_lsu
    import riscv_lsu_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [ADDR_W-1:0]   ALUResultM,
    input  logic [DATA_W-1:0]   WriteDataM,
    input  logic                MemReadM,
    input  logic                MemWriteM,
    input  logic [2:0]          Funct3M,
    input  logic                FlushM,
    output logic                mem_req_valid,
    input  logic                mem_req_ready,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic                mem_we,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W/8-1:0] mem_wstrb,
    input  logic                mem_rsp_valid,
    input  logic [DATA_W-1:0]   mem_rdata,
    output logic [DATA_W-1:0]   ReadDataM,
    output logic                StallM,
    output logic                MisalignM
);
    lsu_state_e state, state_d;
    logic [2:0] f3_q;
    logic [1:0] off_q, off;
    logic       access, mis;
    logic [3:0] wstrb_d;
    logic [31:0] wdata_d, load_result;

    assign off    = ALUResultM[1:0];
    assign access = (MemReadM | MemWriteM) & ~FlushM;

    // Access size comes from funct3[1:0]: 00 byte, 01 half, anything else a word.
    always_comb begin
        wstrb_d = Funct3M[1:0] == 2'b00 ? 4'b0001 << off :
                  Funct3M[1:0] == 2'b01 ? 4'b0011 << {off[1], 1'b0} : 4'b1111;
        wdata_d = Funct3M[1:0] == 2'b00 ? {4{WriteDataM[7:0]}} :
                  Funct3M[1:0] == 2'b01 ? {2{WriteDataM[15:0]}} : WriteDataM;
    end

`ifdef LSU_MISALIGN_TRAP_EN
    assign mis = access & (Funct3M[1:0] == 2'b00 ? 1'b0 :
                           Funct3M[1:0] == 2'b01 ? off[0] : |off);
`else
    assign mis = 1'b0;
    assign MisalignM = 1'b0;
`endif

    lsu_load_align u_align (
        .rdata  (mem_rdata),
        .off    (off_q),
        .funct3 (f3_q),
        .result (load_result)
    );

    assign mem_req_valid = state == REQ;

    always_comb begin
        state_d = state;
        StallM  = 1'b0;
        unique case (state)
            IDLE: begin
                StallM  = access;
                state_d = !access ? IDLE : mis ? DONE : REQ;
            end
            REQ: begin
                StallM  = 1'b1;
                state_d = !mem_req_ready ? REQ : mem_we ? DONE : WAIT;
            end
            WAIT: begin
                StallM  = 1'b1;
                state_d = mem_rsp_valid ? DONE : WAIT;
            end
            DONE: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            mem_addr  <= '0;
            mem_we    <= 1'b0;
            mem_wdata <= '0;
            mem_wstrb <= '0;
            f3_q      <= '0;
            off_q     <= '0;
            ReadDataM <= '0;
        end else begin
            state <= state_d;
            if (state == IDLE && access && !mis) begin
                mem_addr  <= {ALUResultM[ADDR_W-1:2], 2'b00};
                mem_we    <= MemWriteM;
                mem_wdata <= wdata_d;
                mem_wstrb <= wstrb_d;
                f3_q      <= Funct3M;
                off_q     <= off;
            end
            if (state == WAIT && mem_rsp_valid)
                ReadDataM <= load_result;
        end
    end

`ifdef LSU_MISALIGN_TRAP_EN
    // Raised on the IDLE->DONE hop so it is visible during DONE only.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            MisalignM <= 1'b0;
        else
            MisalignM <= state == IDLE && mis;
    end
`endif
endmodule

// File: tb/tb_mem_stage_lsu.sv
// tb_mem_stage_lsu: directed plus randomized bench for mem_stage_lsu against a byte-lane reference model.
module tb_mem_stage_lsu;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] ALUResultM = '0, WriteDataM = '0, mem_rdata = '0;
    logic        MemReadM = 1'b0, MemWriteM = 1'b0, FlushM = 1'b0;
    logic [2:0]  Funct3M = '0;
    logic        mem_req_ready = 1'b0, mem_rsp_valid = 1'b0;
    logic        mem_req_valid, mem_we, StallM, MisalignM;
    logic [31:0] mem_addr, mem_wdata, ReadDataM;
    logic [3:0]  mem_wstrb;

    int checks = 0;
    int errors = 0;
    logic [31:0] model_rd = '0;

    mem_stage_lsu dut (
        .clk           (clk),
        .reset         (reset),
        .ALUResultM    (ALUResultM),
        .WriteDataM    (WriteDataM),
        .MemReadM      (MemReadM),
        .MemWriteM     (MemWriteM),
        .Funct3M       (Funct3M),
        .FlushM        (FlushM),
        .mem_req_valid (mem_req_valid),
        .mem_req_ready (mem_req_ready),
        .mem_addr      (mem_addr),
        .mem_we        (mem_we),
        .mem_wdata     (mem_wdata),
        .mem_wstrb     (mem_wstrb),
        .mem_rsp_valid (mem_rsp_valid),
        .mem_rdata     (mem_rdata),
        .ReadDataM     (ReadDataM),
        .StallM        (StallM),
        .MisalignM     (MisalignM)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic int unsigned sz_of(input logic [2:0] f3);
        return f3[1:0] == 2'd0 ? 1 : f3[1:0] == 2'd1 ? 2 : 4;
    endfunction

    function automatic int unsigned lane0(input logic [2:0] f3, input logic [1:0] off);
        int unsigned s = sz_of(f3);
        return (32'(off) / s) * s;
    endfunction

    function automatic logic [3:0] exp_strb(input logic [2:0] f3, input logic [1:0] off);
        return 4'(((1 << sz_of(f3)) - 1) << lane0(f3, off));
    endfunction

    function automatic logic [31:0] exp_wdata(input logic [2:0] f3, input logic [31:0] wd);
        int unsigned s = sz_of(f3);
        return s == 1 ? wd[7:0] * 32'h01010101 : s == 2 ? wd[15:0] * 32'h00010001 : wd;
    endfunction

    function automatic logic [31:0] exp_load(input logic [2:0] f3, input logic [1:0] off, input logic [31:0] rd);
        int unsigned s = sz_of(f3);
        logic [31:0] mask, v;
        mask = s == 4 ? 32'hFFFFFFFF : (32'd1 << (8 * s)) - 1;
        v = (rd >> (8 * lane0(f3, off))) & mask;
        if (!f3[2] && s < 4 && v[8 * s - 1]) v = v | ~mask;
        return v;
    endfunction

    function automatic logic exp_mis(input logic [2:0] f3, input logic [1:0] off);
`ifdef LSU_MISALIGN_TRAP_EN
        return sz_of(f3) == 2 ? off[0] : sz_of(f3) == 4 ? (off != 2'b00) : 1'b0;
`else
        return 1'b0;
`endif
    endfunction

    task automatic txn(input bit is_store, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wd, input logic [31:0] rdata, input int rdy_dly, input int rsp_dly);
        int stalls;
        logic mis;
        mis = exp_mis(f3, addr[1:0]);
        MemReadM = !is_store; MemWriteM = is_store; Funct3M = f3;
        ALUResultM = addr; WriteDataM = wd; FlushM = 1'b0;
        mem_req_ready = 1'b0; mem_rsp_valid = 1'b0;
        #1;
        chk("stall_idle", StallM, 1);
        chk("req_idle", mem_req_valid, 0);
        stalls = int'(StallM);
        @(posedge clk); #1;
        if (!mis) begin
            for (int i = 0; i <= rdy_dly; i++) begin
                chk("req_valid", mem_req_valid, 1);
                chk("req_addr", mem_addr, addr & 32'hFFFFFFFC);
                chk("req_we", mem_we, is_store);
                if (is_store) begin
                    chk("req_wstrb", mem_wstrb, exp_strb(f3, addr[1:0]));
                    chk("req_wdata", mem_wdata, exp_wdata(f3, wd));
                end
                chk("stall_req", StallM, 1);
                chk("rd_hold_req", ReadDataM, model_rd);
                stalls += int'(StallM);
                FlushM = 1'($urandom_range(0, 1));
                mem_rsp_valid = 1'($urandom_range(0, 1));
                mem_rdata = $urandom;
                mem_req_ready = (i == rdy_dly);
                @(posedge clk); #1;
            end
            mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; FlushM = 1'b0;
            if (!is_store) begin
                for (int i = 0; i < rsp_dly; i++) begin
                    chk("req_drop", mem_req_valid, 0);
                    chk("stall_wait", StallM, 1);
                    chk("rd_hold_wait", ReadDataM, model_rd);
                    stalls += int'(StallM);
                    mem_rsp_valid = (i == rsp_dly - 1);
                    mem_rdata = mem_rsp_valid ? rdata : $urandom;
                    @(posedge clk); #1;
                end
                mem_rsp_valid = 1'b0;
                model_rd = exp_load(f3, addr[1:0], rdata);
            end
        end
        chk("stall_done", StallM, 0);
        chk("misalign_done", MisalignM, mis);
        chk("req_done", mem_req_valid, 0);
        chk("read_data", ReadDataM, model_rd);
        chk("stall_count", stalls, mis ? 1 : 2 + rdy_dly + (is_store ? 0 : rsp_dly));
        MemReadM = 1'b0; MemWriteM = 1'b0;
        @(posedge clk); #1;
        chk("stall_after", StallM, 0);
        chk("misalign_after", MisalignM, 0);
    endtask

    initial begin
        #1;
        chk("rst_valid", mem_req_valid, 0);
        chk("rst_we", mem_we, 0);
        chk("rst_addr", mem_addr, 0);
        chk("rst_wdata", mem_wdata, 0);
        chk("rst_wstrb", mem_wstrb, 0);
        chk("rst_rd", ReadDataM, 0);
        chk("rst_mis", MisalignM, 0);
        chk("rst_stall", StallM, 0);
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;

        txn(1, 3'b010, 32'h100, 32'hDEADBEEF, 32'h0, 0, 1);
        txn(0, 3'b000, 32'h203, 32'h0, 32'h80FF_0000, 0, 1);
        chk("lb_value", ReadDataM, 32'hFFFFFF80);
        txn(0, 3'b100, 32'h203, 32'h0, 32'h80FF_0000, 0, 1);
        chk("lbu_value", ReadDataM, 32'h00000080);
        txn(1, 3'b001, 32'h042, 32'h0000_1234, 32'h0, 0, 1);
        txn(0, 3'b010, 32'h300, 32'h0, 32'hCAFE_F00D, 4, 2);
        chk("lw_value", ReadDataM, 32'hCAFEF00D);

        MemReadM = 1'b1; FlushM = 1'b1; Funct3M = 3'b010; ALUResultM = 32'h400;
        #1;
        chk("flush_stall", StallM, 0);
        @(posedge clk); #1;
        chk("flush_req", mem_req_valid, 0);
        chk("flush_stall2", StallM, 0);
        MemReadM = 1'b0; FlushM = 1'b0;

        txn(0, 3'b010, 32'h101, 32'h0, 32'h1357_9BDF, 0, 1);
        txn(0, 3'b001, 32'h503, 32'h0, 32'h8001_7FFF, 1, 1);
        txn(0, 3'b101, 32'h503, 32'h0, 32'h8001_7FFF, 0, 3);
        txn(1, 3'b000, 32'h602, 32'hA5A5_A5C3, 32'h0, 2, 1);

        for (int n = 0; n < 40; n++) begin
            bit st = 1'($urandom_range(0, 1));
            logic [2:0] f3 = st ? 3'($urandom_range(0, 2)) : 3'($urandom_range(0, 7));
            txn(st, f3, $urandom, $urandom, $urandom, $urandom_range(0, 3), $urandom_range(1, 3));
        end

        txn(0, 3'b010, 32'h700, 32'h0, 32'h1234_5678, 0, 1);
        MemReadM = 1'b1; Funct3M = 3'b010; ALUResultM = 32'h704; mem_req_ready = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        mem_req_ready = 1'b0;
        chk("wait_stall", StallM, 1);
        reset = 1'b0; MemReadM = 1'b0;
        #1;
        chk("rst_mid_valid", mem_req_valid, 0);
        chk("rst_mid_rd", ReadDataM, 0);
        chk("rst_mid_stall", StallM, 0);
        @(posedge clk); #1;
        reset = 1'b1;
        mem_rsp_valid = 1'b1; mem_rdata = 32'hFFFF_EEEE;
        @(posedge clk); #1;
        mem_rsp_valid = 1'b0;
        chk("late_rsp_rd", ReadDataM, 0);
        chk("late_rsp_stall", StallM, 0);
        chk("late_rsp_valid", mem_req_valid, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
